// File: rtl/router_buffer.sv
// ---------------------------------------------------------------------------
// router_buffer
//   Router-side responder to the 4-port router controller. It grants a port
//   request (acknowledge), captures a DEPTH-word packet from the shared data
//   bus under st_router, then replays it under fw_router. All sequencing is
//   driven by the controller's strobes and addresses.
//
// Ports
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   dp_on_bus      one-hot (or multi-hot) port select, [0]=DP1 .. [3]=DP4
//   data_bus       word driven by the selected DataPort
//   st_router      store strobe: write data_bus at inAddr
//   fw_router      forward strobe: read buffer at outAddr
//   inAddr/outAddr store / forward addresses (modulo DEPTH)
//   acknowledge    grant, high while IDLE and any port is on the bus
//   received       1-cycle pulse after the last word is stored
//   data_out       forwarded word, out_valid marks the cycle it is fresh
//   out_port       destination port, bits [1:0] of header word 0
//   src_port       index of the granted input port
//   busy           high while storing or forwarding
//   proto_err      sticky protocol error flag, cleared only by rst
//   dbg_state      current FSM state (0=IDLE, 1=STORE, 2=FORWARD)
//
// Handshake: there is no back-pressure. A strobe is a command that is acted
// on in the cycle it is high, provided it is legal in the current state.
// Illegal strobes (both at once, fw_router outside FORWARD, st_router in
// FORWARD) are dropped and raise proto_err.
// ---------------------------------------------------------------------------
module router_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        dp_on_bus,
    input  logic [DATA_W-1:0] data_bus,
    input  logic              st_router,
    input  logic              fw_router,
    input  logic [ADDR_W-1:0] inAddr,
    input  logic [ADDR_W-1:0] outAddr,
    output logic              acknowledge,
    output logic              received,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic [1:0]        out_port,
    output logic [1:0]        src_port,
    output logic              busy,
    output logic              proto_err,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_STORE   = 2'd1,
        S_FORWARD = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    state_t            w_next_state;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_data_out;
    logic              r_out_valid;
    logic              r_received;
    logic [1:0]        r_out_port;
    logic [1:0]        r_src_port;
    logic              r_proto_err;

    logic              w_wr;
    logic              w_rd;
    logic              w_bad;
    logic [1:0]        w_lowest;

    // A write is legal in IDLE (it starts the packet) and in STORE; a read
    // only in FORWARD. Any strobe that is neither is a protocol error, which
    // also covers both strobes high together.
    assign w_wr  = st_router & ~fw_router & (r_state != S_FORWARD);
    assign w_rd  = fw_router & ~st_router & (r_state == S_FORWARD);
    assign w_bad = (st_router | fw_router) & ~w_wr & ~w_rd;

    // Lowest set bit wins when several ports are on the bus.
    always_comb begin
        w_lowest = 2'd0;
        if (dp_on_bus[0])      w_lowest = 2'd0;
        else if (dp_on_bus[1]) w_lowest = 2'd1;
        else if (dp_on_bus[2]) w_lowest = 2'd2;
        else if (dp_on_bus[3]) w_lowest = 2'd3;
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // ---------------- FSM: next state ----------------
    // Only the DEPTH-1 address ends a phase; other addresses may arrive in
    // any order.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_wr) w_next_state = (inAddr == LAST_ADDR) ? S_FORWARD : S_STORE;
            end
            S_STORE: begin
                if (w_wr && inAddr == LAST_ADDR) w_next_state = S_FORWARD;
            end
            S_FORWARD: begin
                if (w_rd && outAddr == LAST_ADDR) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        acknowledge = (r_state == S_IDLE) & (|dp_on_bus);
        busy        = (r_state != S_IDLE);
        dbg_state   = r_state;
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src_port  <= 2'd0;
            r_out_port  <= 2'd0;
            r_received  <= 1'b0;
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            // The port is granted on the first store of a packet only.
            if (w_wr && r_state == S_IDLE) r_src_port <= w_lowest;
            // Word 0 is the header; its low bits name the destination.
            if (w_wr && inAddr == '0)      r_out_port <= data_bus[1:0];
            r_received  <= w_wr && (inAddr == LAST_ADDR);
            r_out_valid <= w_rd;
            if (w_rd)  r_data_out  <= r_mem[outAddr];
            if (w_bad) r_proto_err <= 1'b1;
        end
    end

    // Buffer contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[inAddr] <= data_bus;
    end

    assign received  = r_received;
    assign data_out  = r_data_out;
    assign out_valid = r_out_valid;
    assign out_port  = r_out_port;
    assign src_port  = r_src_port;
    assign proto_err = r_proto_err;

endmodule

// File: tb/tb_router_buffer.sv
module tb_router_buffer;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    dp_on_bus;
    logic [DW-1:0] data_bus;
    logic          st_router;
    logic          fw_router;
    logic [AW-1:0] inAddr;
    logic [AW-1:0] outAddr;
    logic          acknowledge;
    logic          received;
    logic [DW-1:0] data_out;
    logic          out_valid;
    logic [1:0]    out_port;
    logic [1:0]    src_port;
    logic          busy;
    logic          proto_err;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    router_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .dp_on_bus  (dp_on_bus),
        .data_bus   (data_bus),
        .st_router  (st_router),
        .fw_router  (fw_router),
        .inAddr     (inAddr),
        .outAddr    (outAddr),
        .acknowledge(acknowledge),
        .received   (received),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .out_port   (out_port),
        .src_port   (src_port),
        .busy       (busy),
        .proto_err  (proto_err),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard / counters ----------------
    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase of the packet life: 0 waiting, 1 collecting words, 2 replaying.
    int            m_phase;
    logic [DW-1:0] m_mem [DEPTH];
    logic [1:0]    m_src, m_dst;
    logic [DW-1:0] m_dout;
    logic          m_valid, m_recv, m_err;
    logic [DW-1:0] pkt [DEPTH];

    function automatic logic [1:0] lowest(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) if (v[i]) r = 2'(i);
        return r;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_src = 0; m_dst = 0; m_dout = 0;
        m_valid = 0; m_recv = 0; m_err = 0;
        exp_q.delete();
    endtask

    task automatic model_cycle();
        m_recv  = 0;
        m_valid = 0;
        if (st_router && fw_router) begin
            m_err = 1;
        end else if (st_router && m_phase != 2) begin
            if (m_phase == 0) m_src = lowest(dp_on_bus);
            m_mem[inAddr] = data_bus;
            if (inAddr == 0) m_dst = data_bus[1:0];
            if (inAddr == AW'(DEPTH - 1)) begin
                m_recv  = 1;
                m_phase = 2;
            end else begin
                m_phase = 1;
            end
        end else if (fw_router && m_phase == 2) begin
            m_dout  = m_mem[outAddr];
            m_valid = 1;
            exp_q.push_back(m_dout);
            if (outAddr == AW'(DEPTH - 1)) m_phase = 0;
        end else if (st_router || fw_router) begin
            m_err = 1;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".acknowledge"}, 32'(acknowledge), 32'((m_phase == 0) && (dp_on_bus != 0)));
        chk({tag, ".busy"},        32'(busy),        32'(m_phase != 0));
        chk({tag, ".received"},    32'(received),    32'(m_recv));
        chk({tag, ".out_valid"},   32'(out_valid),   32'(m_valid));
        chk({tag, ".data_out"},    32'(data_out),    32'(m_dout));
        chk({tag, ".out_port"},    32'(out_port),    32'(m_dst));
        chk({tag, ".src_port"},    32'(src_port),    32'(m_src));
        chk({tag, ".proto_err"},   32'(proto_err),   32'(m_err));
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change at the falling edge; outputs are sampled 1 ns after the
    // rising edge.
    task automatic step(input string tag);
        logic [DW-1:0] w;
        @(posedge clk);
        model_cycle();
        #1;
        check_outputs(tag);
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk({tag, ".sb_underflow"}, 32'(1), 32'(0));
            end else begin
                w = exp_q.pop_front();
                chk({tag, ".sb_word"}, 32'(data_out), 32'(w));
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input string tag, input logic st, input logic fw,
                         input logic [AW-1:0] ia, input logic [AW-1:0] oa,
                         input logic [DW-1:0] d);
        st_router = st;
        fw_router = fw;
        inAddr    = ia;
        outAddr   = oa;
        data_bus  = d;
        step(tag);
    endtask

    task automatic idle_cycle(input string tag);
        drive(tag, 1'b0, 1'b0, AW'($urandom_range(0, DEPTH - 1)),
              AW'($urandom_range(0, DEPTH - 1)), DW'($urandom));
    endtask

    task automatic store_pkt(input string tag, input int first, input int last, input bit gapped);
        for (int i = first; i <= last; i++) begin
            if (gapped && $urandom_range(0, 2) == 0) idle_cycle({tag, ".gap"});
            drive(tag, 1'b1, 1'b0, AW'(i), AW'($urandom_range(0, DEPTH - 1)), pkt[i]);
        end
    endtask

    // mode 0: back-to-back, 1: alternating gaps, 2: random gaps
    task automatic fwd_pkt(input string tag, input int mode);
        for (int i = 0; i < DEPTH; i++) begin
            if (mode == 1 && i != 0) idle_cycle({tag, ".gap"});
            if (mode == 2 && $urandom_range(0, 1) == 0) idle_cycle({tag, ".gap"});
            drive(tag, 1'b0, 1'b1, AW'($urandom_range(0, DEPTH - 1)), AW'(i), DW'($urandom));
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic random_pkt();
        for (int i = 0; i < DEPTH; i++) pkt[i] = DW'($urandom);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        dp_on_bus = 4'b0000;
        data_bus  = '0;
        st_router = 1'b0;
        fw_router = 1'b0;
        inAddr    = '0;
        outAddr   = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Port 3 request, header 02 then 11..1F, then clean replay.
        dp_on_bus = 4'b0100;
        idle_cycle("t2.grant");
        pkt[0] = 8'h02;
        for (int i = 1; i < DEPTH; i++) pkt[i] = DW'(8'h10 + i);
        store_pkt("t2.store", 0, DEPTH - 1, 1'b0);
        fwd_pkt("t3.fwd", 0);
        idle_cycle("t3.after");

        // Two ports requesting: lowest index granted, no ack while busy.
        dp_on_bus = 4'b1010;
        idle_cycle("t4.grant");
        random_pkt();
        store_pkt("t4.store", 0, DEPTH - 1, 1'b1);
        fwd_pkt("t4.fwd", 2);

        // Reset in the middle of a packet.
        dp_on_bus = 4'b1000;
        random_pkt();
        store_pkt("t1.partial", 0, 6, 1'b0);
        dp_on_bus = 4'b0010;
        do_reset("t1.reset");
        idle_cycle("t1.ack");
        random_pkt();
        store_pkt("t1.store", 0, DEPTH - 1, 1'b0);

        // Gapped forwarding.
        fwd_pkt("t6.fwd", 1);

        // Conflicting strobes at word 5: the word is dropped, error sticks.
        dp_on_bus = 4'b0001;
        random_pkt();
        store_pkt("t5.store", 0, 4, 1'b0);
        drive("t5.both", 1'b1, 1'b1, AW'(5), AW'(5), 8'hEE);
        store_pkt("t5.store", 6, DEPTH - 1, 1'b0);
        fwd_pkt("t5.fwd", 0);
        random_pkt();
        store_pkt("t5.good", 0, DEPTH - 1, 1'b1);
        fwd_pkt("t5.good", 2);
        do_reset("t5.clear");
        idle_cycle("t5.cleared");

        // Random soak: arbitrary strobes, addresses and port selects.
        for (int n = 0; n < 600; n++) begin
            dp_on_bus = 4'($urandom);
            drive("soak", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                  AW'($urandom_range(0, DEPTH - 1)), AW'($urandom_range(0, DEPTH - 1)),
                  DW'($urandom));
            if ($urandom_range(0, 199) == 0) do_reset("soak.reset");
        end

        st_router = 1'b0;
        fw_router = 1'b0;
        idle_cycle("final");
        chk("sb_drain", 32'(exp_q.size()), 32'(0));
        do_reset("final.reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
